// File: rtl/prog_rom_pkg.sv
// Shared definitions for the program ROM: the default program image,
// the controller state encoding and the store depth.
package prog_rom_pkg;

  localparam int PROG_DEPTH  = 16;
  localparam int PROG_WORD_W = 8;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2,
    CHECK = 2'd3
  } ROM_STATE;

  // TD4 LED-blink program: OUT patterns sweep a lit pair across the LEDs,
  // then JMP 0. Unused tail entries are zero.
  localparam logic [PROG_WORD_W-1:0] DEFAULT_PROG [PROG_DEPTH] = '{
    8'hB3, 8'hB6, 8'hBC, 8'hB8, 8'hB8, 8'hBC, 8'hB6, 8'hB3,
    8'hB1, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Looks up one word of the default program.
  function automatic logic [PROG_WORD_W-1:0] defaultWord(input logic [3:0] idx);
    return DEFAULT_PROG[idx];
  endfunction

endpackage

// File: rtl/prog_rom_store.sv
// Single-ported instruction store with synchronous write and a registered
// read. A cycle without a read enable returns zero on the next cycle, so
// the fetched word is a NOP whenever the controller is not running.
module prog_rom_store #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Array write; contents are not reset, the controller rewrites them.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read port, forced to zero when no read is requested.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_rom.sv
// Program-memory responder for the CPU fetch path. After reset it copies
// the default program into the store, then serves fetches with one cycle
// of latency. A byte-serial loader can replace the program at run time;
// hold stays high while the store is being written.
// Optional checksum verification of a load: define PROG_ROM_CHECKSUM_EN.
module prog_rom
  import prog_rom_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              hold,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_sum,
  output logic              ld_err
);

  ROM_STATE          r_state;
  ROM_STATE          w_stateNext;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptrNext;
  logic              w_we;
  logic              w_re;
  logic [DATA_W-1:0] w_wdata;
  logic [ADDR_W-1:0] w_memAddr;

`ifdef PROG_ROM_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] w_sumNext;
  logic              r_err;
  logic              w_errNext;
`endif

  // State, pointer and checksum registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_ptr   <= '0;
`ifdef PROG_ROM_CHECKSUM_EN
      r_sum   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_stateNext;
      r_ptr   <= w_ptrNext;
`ifdef PROG_ROM_CHECKSUM_EN
      r_sum   <= w_sumNext;
      r_err   <= w_errNext;
`endif
    end
  end

  // Next-state logic and store control; the store is only read in RUN,
  // and never in the cycle a load is requested, so fetched data is zero
  // whenever hold is high.
  always_comb begin
    w_stateNext = r_state;
    w_ptrNext   = r_ptr;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_wdata     = ld_data;
    hold        = 1'b1;
    ld_ready    = 1'b0;
`ifdef PROG_ROM_CHECKSUM_EN
    w_sumNext   = r_sum;
    w_errNext   = r_err;
`endif
    case (r_state)
      INIT: begin
        w_we      = 1'b1;
        w_wdata   = DATA_W'(defaultWord(4'(r_ptr)));
        w_ptrNext = r_ptr + 1'b1;
        if (&r_ptr) begin
          w_stateNext = RUN;
        end
      end
      RUN: begin
        hold = 1'b0;
        if (ld_start) begin
          w_stateNext = LOAD;
          w_ptrNext   = '0;
`ifdef PROG_ROM_CHECKSUM_EN
          w_sumNext   = '0;
          w_errNext   = 1'b0;
`endif
        end else begin
          w_re = 1'b1;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_start) begin
          w_ptrNext = '0;
`ifdef PROG_ROM_CHECKSUM_EN
          w_sumNext = '0;
          w_errNext = 1'b0;
`endif
        end else if (ld_valid) begin
          w_we      = 1'b1;
          w_ptrNext = r_ptr + 1'b1;
`ifdef PROG_ROM_CHECKSUM_EN
          w_sumNext = r_sum + ld_data;
          if (&r_ptr) begin
            w_stateNext = CHECK;
          end
`else
          if (&r_ptr) begin
            w_stateNext = RUN;
          end
`endif
        end
      end
`ifdef PROG_ROM_CHECKSUM_EN
      CHECK: begin
        w_ptrNext = '0;
        if (r_sum == ld_sum) begin
          w_stateNext = RUN;
        end else begin
          w_errNext   = 1'b1;
          w_stateNext = INIT;
        end
      end
`endif
      default: begin
        w_stateNext = INIT;
        w_ptrNext   = '0;
      end
    endcase
  end

  assign w_memAddr = w_we ? r_ptr : addr;

`ifdef PROG_ROM_CHECKSUM_EN
  assign ld_err = r_err;
`else
  logic w_unusedSum;
  assign w_unusedSum = ^ld_sum;
  assign ld_err      = 1'b0;
`endif

  prog_rom_store #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_store (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_addr (w_memAddr),
    .i_wdata(w_wdata),
    .o_rdata(data)
  );

endmodule
